// File: rtl/xor_accumulator.sv
// Folds masked packet beats into per-row XOR parity across a coding word and
// presents the result, its beat count and a sticky saturation flag until taken.
module xor_accumulator #(
  parameter int MASK_W        = 128,
  parameter int W             = 4,
  parameter int PACKET_LENGTH = 2,
  parameter int CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [PACKET_LENGTH-1:0] mask_product [0:W-1][0:MASK_W-1],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PACKET_LENGTH-1:0] out_parity [0:W-1],
  output logic [CNT_W-1:0]         out_beats,
  output logic                     out_sat,
  output logic [1:0]               dbg_state
);

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // a result transfers where out_valid && out_ready. clr overrides both.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_HOLD = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                   r_state, w_state_nxt;
  logic                     r_live;
  logic [PACKET_LENGTH-1:0] r_acc     [0:W-1];
  logic [PACKET_LENGTH-1:0] r_res     [0:W-1];
  logic [PACKET_LENGTH-1:0] w_red     [0:W-1];
  logic [PACKET_LENGTH-1:0] w_fold    [0:W-1];
  logic [CNT_W-1:0]         r_cnt, r_res_beats, w_cnt_inc;
  logic                     r_sat, r_res_sat, w_sat_inc;
  logic                     w_accept;

  always_comb begin
    for (int i = 0; i < W; i++) begin
      w_red[i] = '0;
      for (int j = 0; j < MASK_W; j++) w_red[i] = w_red[i] ^ mask_product[i][j];
      w_fold[i] = r_acc[i] ^ w_red[i];
    end
  end

  assign w_accept  = in_valid && in_ready;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_sat_inc = r_sat || (r_cnt == CNT_MAX);

  // in_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_nxt = in_last ? S_HOLD : S_ACCUM;
        S_ACCUM: if (w_accept && in_last) w_state_nxt = S_HOLD;
        S_HOLD:  if (out_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = r_live && (r_state != S_HOLD);
    out_valid = (r_state == S_HOLD);
    out_beats = out_valid ? r_res_beats : '0;
    out_sat   = out_valid && r_res_sat;
    dbg_state = r_state;
    for (int i = 0; i < W; i++) out_parity[i] = out_valid ? r_res[i] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < W; i++) begin
        r_acc[i] <= '0;
        r_res[i] <= '0;
      end
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_res_beats <= '0;
      r_res_sat   <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < W; i++) begin
        r_acc[i] <= '0;
        r_res[i] <= '0;
      end
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_res_beats <= '0;
      r_res_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && in_last) begin
            for (int i = 0; i < W; i++) r_res[i] <= w_red[i];
            r_res_beats <= CNT_W'(1);
            r_res_sat   <= 1'b0;
          end else if (w_accept) begin
            for (int i = 0; i < W; i++) r_acc[i] <= w_red[i];
            r_cnt <= CNT_W'(1);
            r_sat <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (w_accept && in_last) begin
            for (int i = 0; i < W; i++) begin
              r_res[i] <= w_fold[i];
              r_acc[i] <= '0;
            end
            r_res_beats <= w_cnt_inc;
            r_res_sat   <= w_sat_inc;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
          end else if (w_accept) begin
            for (int i = 0; i < W; i++) r_acc[i] <= w_fold[i];
            r_cnt <= w_cnt_inc;
            r_sat <= w_sat_inc;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            for (int i = 0; i < W; i++) r_res[i] <= '0;
            r_res_beats <= '0;
            r_res_sat   <= 1'b0;
          end
        end
        default: begin
          r_cnt <= '0;
          r_sat <= 1'b0;
        end
      endcase
    end
  end

endmodule
